// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and helpers for the EXE-stage hazard/forwarding controller.
// Register fields are carried at MAX_REG_W bits. Narrower addresses are zero-extended.
package hazard_fwd_ctrl_pkg;

  localparam int MAX_REG_W = 8;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] dest;
    logic                 wb_en;
    logic                 mem_r_en;
    logic                 mem_w_en;
  } stage_t;

  typedef struct packed {
    stage_t               st;
    logic [MAX_REG_W-1:0] src1;
    logic [MAX_REG_W-1:0] src2;
    logic                 use_src2;
  } exe_stage_t;

  function automatic logic raw_hit(input stage_t s, input logic [MAX_REG_W-1:0] r);
    return s.valid & s.wb_en & (s.dest == r);
  endfunction

  // A load in MEM has no result yet, so it cannot forward; MEM wins over WB.
  function automatic logic [1:0] fwd_pick(input stage_t mem, input stage_t wb,
                                          input logic [MAX_REG_W-1:0] src);
    if (raw_hit(mem, src) && !mem.mem_r_en) return SEL_MEM;
    if (raw_hit(wb, src))                   return SEL_WB;
    return SEL_RF;
  endfunction

endpackage

// File: rtl/hazard_fwd_stage_reg.sv
// One shadow pipeline stage: holds while frozen, loads a zeroed bubble on request.
module hazard_fwd_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (!hold)
      q <= bubble ? '0 : d;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// EXE-stage sequencing controller: operand forwarding selects, load-use/RAW stall,
// branch flush, memory freeze and a saturating stall/freeze cycle counter.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int FWD_EN = 1,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src2,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             id_mem_w_en,
  input  logic             id_valid,
  input  logic             exe_br_taken,
  input  logic             mem_ready,
  output logic [1:0]       sel_src1,
  output logic [1:0]       sel_src2,
  output logic             stall,
  output logic             flush,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt
);

  exe_stage_t           exe_d, exe_q;
  stage_t               mem_q, wb_q;
  logic [MAX_REG_W-1:0] id_s1, id_s2;
  logic                 raw_exe, raw_mem, hazard;

  assign id_s1 = MAX_REG_W'(id_src1);
  assign id_s2 = MAX_REG_W'(id_src2);

  assign exe_d.st.valid    = 1'b1;
  assign exe_d.st.dest     = MAX_REG_W'(id_dest);
  assign exe_d.st.wb_en    = id_wb_en;
  assign exe_d.st.mem_r_en = id_mem_r_en;
  assign exe_d.st.mem_w_en = id_mem_w_en;
  assign exe_d.src1        = id_s1;
  assign exe_d.src2        = id_s2;
  assign exe_d.use_src2    = id_use_src2;

  hazard_fwd_stage_reg #(.W($bits(exe_stage_t))) u_exe (
    .clk    (clk),
    .rst    (rst),
    .hold   (freeze),
    .bubble (stall | flush | ~id_valid),
    .d      (exe_d),
    .q      (exe_q)
  );

  hazard_fwd_stage_reg #(.W($bits(stage_t))) u_mem (
    .clk    (clk),
    .rst    (rst),
    .hold   (freeze),
    .bubble (1'b0),
    .d      (exe_q.st),
    .q      (mem_q)
  );

  hazard_fwd_stage_reg #(.W($bits(stage_t))) u_wb (
    .clk    (clk),
    .rst    (rst),
    .hold   (freeze),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  assign freeze = mem_q.valid & (mem_q.mem_r_en | mem_q.mem_w_en) & ~mem_ready;
  assign flush  = exe_br_taken & exe_q.st.valid & ~freeze;

  assign raw_exe = raw_hit(exe_q.st, id_s1) | (id_use_src2 & raw_hit(exe_q.st, id_s2));
  assign raw_mem = raw_hit(mem_q, id_s1)    | (id_use_src2 & raw_hit(mem_q, id_s2));

  // With forwarding only a load in EXE is uncoverable; without it any EXE/MEM producer is.
  assign hazard = (FWD_EN != 0) ? (id_valid & exe_q.st.mem_r_en & raw_exe)
                                : (id_valid & (raw_exe | raw_mem));
  assign stall  = hazard & ~flush & ~freeze;

  always_comb begin
    sel_src1 = SEL_RF;
    sel_src2 = SEL_RF;
    if (FWD_EN != 0 && exe_q.st.valid) begin
      sel_src1 = fwd_pick(mem_q, wb_q, exe_q.src1);
      if (exe_q.use_src2)
        sel_src2 = fwd_pick(mem_q, wb_q, exe_q.src2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if ((stall | freeze) && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: one forwarding instance and one no-forwarding
// instance with a 4-bit counter, sharing stimulus; expectations go through a scoreboard queue.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, id_dest;
  logic       id_use_src2, id_wb_en, id_mem_r_en, id_mem_w_en, id_valid;
  logic       exe_br_taken, mem_ready;

  logic [1:0]  sel_src1, sel_src2, sel_src1_nf, sel_src2_nf;
  logic        stall, flush, freeze, stall_nf, flush_nf, freeze_nf;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt_nf;

  typedef struct {
    string       tag;
    bit          nf;
    logic [22:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.FWD_EN(1), .REG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_use_src2(id_use_src2), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
    .id_valid(id_valid), .exe_br_taken(exe_br_taken), .mem_ready(mem_ready),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .stall(stall), .flush(flush),
    .freeze(freeze), .stall_cnt(stall_cnt)
  );

  hazard_fwd_ctrl #(.FWD_EN(0), .REG_W(4), .CNT_W(4)) dut_nf (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_use_src2(id_use_src2), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
    .id_valid(id_valid), .exe_br_taken(exe_br_taken), .mem_ready(mem_ready),
    .sel_src1(sel_src1_nf), .sel_src2(sel_src2_nf), .stall(stall_nf), .flush(flush_nf),
    .freeze(freeze_nf), .stall_cnt(stall_cnt_nf)
  );

  task automatic id_instr(input logic [3:0] s1, input logic [3:0] s2, input logic u2,
                          input logic [3:0] d, input logic wb, input logic mr, input logic mw);
    id_src1 = s1; id_src2 = s2; id_use_src2 = u2; id_dest = d;
    id_wb_en = wb; id_mem_r_en = mr; id_mem_w_en = mw; id_valid = 1'b1;
  endtask

  task automatic id_idle();
    id_src1 = '0; id_src2 = '0; id_use_src2 = 1'b0; id_dest = '0;
    id_wb_en = 1'b0; id_mem_r_en = 1'b0; id_mem_w_en = 1'b0; id_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input bit nf, input logic [1:0] e1,
                            input logic [1:0] e2, input logic est, input logic efl,
                            input logic efz, input logic [15:0] ecnt);
    exp_t e;
    e.tag = tag;
    e.nf  = nf;
    e.exp = {e1, e2, est, efl, efz, ecnt};
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, drain the scoreboard, then move to the next cycle.
  task automatic check_cycle();
    exp_t        e;
    logic [22:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.nf)
        obs = {sel_src1_nf, sel_src2_nf, stall_nf, flush_nf, freeze_nf, 12'd0, stall_cnt_nf};
      else
        obs = {sel_src1, sel_src2, stall, flush, freeze, stall_cnt};
      n_total++;
      assert (obs === e.exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed sel1/sel2/stall/flush/freeze/cnt=%h expected=%h",
                  e.tag, obs, e.exp);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    id_idle();
    exe_br_taken = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    id_idle();
    exe_br_taken = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_out("reset_fwd", 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset_nf",  1, 0, 0, 0, 0, 0, 0);
    check_cycle();

    // Forwarding: ADD r1; SUB r2,r1,r3; EOR r1,r1,r9; MOV r1; CMP r1,(r1 unused)
    id_instr(2, 3, 1, 1, 1, 0, 0);
    expect_out("fwd_c1", 0, 0, 0, 0, 0, 0, 0);
    check_cycle();
    id_instr(1, 3, 1, 2, 1, 0, 0);
    expect_out("fwd_c2_add_in_exe", 0, 0, 0, 0, 0, 0, 0);
    check_cycle();
    id_instr(1, 9, 1, 1, 1, 0, 0);
    expect_out("fwd_mem_src1", 0, 1, 0, 0, 0, 0, 0);
    check_cycle();
    id_instr(10, 11, 0, 1, 1, 0, 0);
    expect_out("fwd_wb_src1", 0, 2, 0, 0, 0, 0, 0);
    check_cycle();
    id_instr(1, 1, 0, 0, 0, 0, 0);
    expect_out("fwd_none", 0, 0, 0, 0, 0, 0, 0);
    check_cycle();
    id_idle();
    expect_out("fwd_mem_prio_use2_gate", 0, 1, 0, 0, 0, 0, 0);
    check_cycle();

    // Load-use: LDR r4 then ADD r6,r7,r4
    id_instr(5, 0, 0, 4, 1, 1, 0);
    expect_out("lu_ldr_id", 0, 0, 0, 0, 0, 0, 0);
    check_cycle();
    id_instr(7, 4, 1, 6, 1, 0, 0);
    expect_out("lu_stall", 0, 0, 0, 1, 0, 0, 0);
    check_cycle();
    expect_out("lu_bubble", 0, 0, 0, 0, 0, 0, 1);
    check_cycle();
    id_idle();
    expect_out("lu_wb_src2", 0, 0, 2, 0, 0, 0, 1);
    check_cycle();

    // No forwarding: ADD r1 then a reader of r1 stalls two cycles
    do_reset();
    id_instr(2, 3, 1, 1, 1, 0, 0);
    expect_out("nf_add", 1, 0, 0, 0, 0, 0, 0);
    check_cycle();
    id_instr(1, 3, 1, 2, 1, 0, 0);
    expect_out("nf_stall_exe", 1, 0, 0, 1, 0, 0, 0);
    check_cycle();
    expect_out("nf_stall_mem", 1, 0, 0, 1, 0, 0, 1);
    check_cycle();
    expect_out("nf_release", 1, 0, 0, 0, 0, 0, 2);
    check_cycle();
    id_idle();
    expect_out("nf_sel_zero", 1, 0, 0, 0, 0, 0, 2);
    check_cycle();

    // Freeze: MOV r8; STR; ADD r7,r8,r9; store stuck in MEM for 5 cycles
    do_reset();
    id_instr(1, 2, 1, 8, 1, 0, 0);
    expect_out("fz_mov", 0, 0, 0, 0, 0, 0, 0);
    check_cycle();
    id_instr(5, 6, 1, 0, 0, 0, 1);
    expect_out("fz_str", 0, 0, 0, 0, 0, 0, 0);
    check_cycle();
    id_instr(8, 9, 1, 7, 1, 0, 0);
    expect_out("fz_add", 0, 0, 0, 0, 0, 0, 0);
    check_cycle();
    id_instr(11, 12, 1, 10, 1, 0, 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("fz_hold_%0d", i), 0, 2, 0, 0, 0, 1, 16'(i));
      check_cycle();
    end
    mem_ready = 1'b1;
    expect_out("fz_release", 0, 2, 0, 0, 0, 0, 5);
    check_cycle();
    id_instr(5, 0, 0, 4, 1, 1, 0);
    expect_out("fz_advanced", 0, 0, 0, 0, 0, 0, 5);
    check_cycle();

    // Flush beats load-use stall; then the bubble leaves nothing to flush
    id_instr(4, 7, 1, 6, 1, 0, 0);
    exe_br_taken = 1'b1;
    expect_out("fl_beats_stall", 0, 0, 0, 0, 1, 0, 5);
    check_cycle();
    expect_out("fl_exe_bubble", 0, 0, 0, 0, 0, 0, 5);
    check_cycle();
    exe_br_taken = 1'b0;
    id_instr(5, 0, 0, 4, 1, 1, 0);
    expect_out("fl_refill", 0, 2, 0, 0, 0, 0, 5);
    check_cycle();
    id_instr(11, 12, 1, 10, 1, 0, 0);
    expect_out("fl_ldr_exe", 0, 0, 0, 0, 0, 0, 5);
    check_cycle();
    id_idle();
    exe_br_taken = 1'b1;
    mem_ready = 1'b0;
    expect_out("fl_deferred_0", 0, 0, 0, 0, 0, 1, 5);
    check_cycle();
    expect_out("fl_deferred_1", 0, 0, 0, 0, 0, 1, 6);
    check_cycle();
    mem_ready = 1'b1;
    expect_out("fl_after_freeze", 0, 0, 0, 0, 1, 0, 7);
    check_cycle();
    exe_br_taken = 1'b0;
    expect_out("fl_idle", 0, 0, 0, 0, 0, 0, 7);
    check_cycle();

    // Saturation on the 4-bit counter, then reset in the middle of a freeze
    do_reset();
    id_instr(5, 6, 1, 0, 0, 0, 1);
    expect_out("sat_str", 1, 0, 0, 0, 0, 0, 0);
    check_cycle();
    id_idle();
    expect_out("sat_str_exe", 1, 0, 0, 0, 0, 0, 0);
    check_cycle();
    mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      expect_out($sformatf("sat_nf_%0d", i), 1, 0, 0, 0, 0, 1, 16'((i > 15) ? 15 : i));
      expect_out($sformatf("sat_fwd_%0d", i), 0, 0, 0, 0, 0, 1, 16'(i));
      check_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_out("rst_mid_freeze_nf",  1, 0, 0, 0, 0, 0, 0);
    expect_out("rst_mid_freeze_fwd", 0, 0, 0, 0, 0, 0, 0);
    check_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
